tmds_decoder_align: RTL and testbench

Single-channel TMDS receive decoder with word-alignment control, the receive-side counterpart of the TMDS encoder used on the HDMI output path. It takes 10-bit symbols from one deserializer lane on the pixel clock, finds word alignment by hunting for runs of control tokens and pulsing a bitslip request back to the deserializer, then decodes the aligned symbols into 8-bit pixel data, DE and the C0/C1 control bits. One instance per TMDS lane sits between the deserializer and the video timing/FIFO write logic.

---
 rtl/tmds_decoder_align.sv | 113 +++++++++++
 tb/tb_tmds_decoder_align.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder_align.sv
// tmds_decoder_align: TMDS lane decoder with token-run word alignment and bitslip control.
// Define TMDS_DEC_STATS_EN to enable the saturating lock-loss counter; otherwise lock_loss_cnt is tied to 0.
module tmds_decoder_align #(
  parameter int LOCK_CNT   = 16,
  parameter int SEARCH_WIN = 4096,
  parameter int SLIP_WAIT  = 8,
  parameter int LOSS_WIN   = 65536
) (
  input  logic       low_clk,
  input  logic       s_rst,
  input  logic [9:0] sym_in,
  output logic       bitslip,
  output logic [3:0] slip_cnt,
  output logic       locked,
  output logic [7:0] d_out,
  output logic       c0_out,
  output logic       c1_out,
  output logic       de_out,
  output logic [7:0] lock_loss_cnt
);
  localparam int TBIG = LOSS_WIN > SEARCH_WIN ? LOSS_WIN : SEARCH_WIN;
  localparam int TMAX = TBIG > SLIP_WAIT ? TBIG : SLIP_WAIT;
  localparam int TW   = $clog2(TMAX);
  localparam int RW   = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [RW-1:0] run, run_nxt;
  logic [9:0] q;
  logic [7:0] t, d;
  logic [1:0] tok;
  logic is_ctl, run_hit, lk_nxt, show;
  assign is_ctl = q == 10'b1101010100 || q == 10'b0010101011 ||
                  q == 10'b0101010100 || q == 10'b1010101011;
  assign tok = q == 10'b1101010100 ? 2'b00 :
               q == 10'b0010101011 ? 2'b01 :
               q == 10'b0101010100 ? 2'b10 : 2'b11;
  assign t = q[9] ? ~q[7:0] : q[7:0];
  assign d = {t[7:1] ^ t[6:0] ^ {7{~q[8]}}, t[0]};
  // run counter is frozen at zero while a slip settles so stale tokens cannot lock
  assign run_nxt = (state == SLIP || state == WAIT || !is_ctl) ? '0 :
                   run == RW'(LOCK_CNT) ? run : run + 1'b1;
  assign run_hit = is_ctl && run == RW'(LOCK_CNT - 1);
  assign lk_nxt  = state_nxt == LOCKED;
  assign show    = lk_nxt && !is_ctl;
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    case (state)
      SEARCH: begin
        if (run_hit) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
        end else if (timer == TW'(SEARCH_WIN - 1)) begin
          state_nxt = SLIP;
          timer_nxt = '0;
        end
      end
      SLIP: begin
        state_nxt = WAIT;
        timer_nxt = '0;
      end
      WAIT: begin
        if (timer == TW'(SLIP_WAIT - 1)) begin
          state_nxt = SEARCH;
          timer_nxt = '0;
        end
      end
      LOCKED: begin
        if (run_hit) timer_nxt = '0;
        else if (timer == TW'(LOSS_WIN - 1)) begin
          state_nxt = SEARCH;
          timer_nxt = '0;
        end
      end
    endcase
  end
  always_ff @(posedge low_clk or posedge s_rst) begin
    if (s_rst) begin
      state    <= SEARCH;
      timer    <= '0;
      run      <= '0;
      q        <= '0;
      bitslip  <= 1'b0;
      slip_cnt <= '0;
      locked   <= 1'b0;
      d_out    <= '0;
      de_out   <= 1'b0;
      c0_out   <= 1'b0;
      c1_out   <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      run     <= run_nxt;
      q       <= sym_in;
      bitslip <= state == SLIP;
      if (state == SLIP) slip_cnt <= slip_cnt == 4'd9 ? 4'd0 : slip_cnt + 4'd1;
      locked  <= lk_nxt;
      de_out  <= show;
      d_out   <= show ? d : 8'h00;
      if (is_ctl) {c1_out, c0_out} <= tok;
    end
  end
`ifdef TMDS_DEC_STATS_EN
  always_ff @(posedge low_clk or posedge s_rst) begin
    if (s_rst) lock_loss_cnt <= '0;
    else if (state == LOCKED && state_nxt == SEARCH && lock_loss_cnt != 8'hFF)
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`else
  assign lock_loss_cnt = '0;
`endif
endmodule

// File: tb/tb_tmds_decoder_align.sv
// tb_tmds_decoder_align: scoreboard bench for decode/gating plus directed alignment, wrap, loss and reset checks.
module tb_tmds_decoder_align;
  localparam int LC = 16, SW = 48, SWT = 8, LW = 80, PER = SW + SWT + 1;
  localparam logic [9:0] T00 = 10'b1101010100, T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100, T11 = 10'b1010101011;
  localparam logic [9:0] DATA = 10'b0100000000;
`ifdef TMDS_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic low_clk = 1'b0, s_rst = 1'b1;
  logic [9:0] sym_in = '0;
  logic bitslip, locked, c0_out, c1_out, de_out;
  logic [3:0] slip_cnt;
  logic [7:0] d_out, lock_loss_cnt;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {int due; logic lk; logic de; logic [7:0] d; logic [1:0] c;} exp_t;
  exp_t sb[$];
  exp_t e;

  tmds_decoder_align #(.LOCK_CNT(LC), .SEARCH_WIN(SW), .SLIP_WAIT(SWT), .LOSS_WIN(LW)) dut (
    .low_clk(low_clk), .s_rst(s_rst), .sym_in(sym_in), .bitslip(bitslip),
    .slip_cnt(slip_cnt), .locked(locked), .d_out(d_out), .c0_out(c0_out),
    .c1_out(c1_out), .de_out(de_out), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 low_clk = ~low_clk;
  always @(posedge low_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge low_clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("sb_late", cyc, e.due);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("sb_locked", locked, e.lk);
      chk("sb_de", de_out, e.de);
      chk("sb_d", d_out, e.d);
      chk("sb_c", {c1_out, c0_out}, e.c);
    end
  end

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] x;
    x = {w, w};
    return x[k +: 10];
  endfunction

  task automatic step(input logic [9:0] v);
    @(posedge low_clk);
    #1 sym_in = v;
  endtask

  task automatic send(input logic [9:0] v, input logic lk, input logic de, input logic [7:0] d, input logic [1:0] c);
    step(v);
    sb.push_back('{due: cyc + 2, lk: lk, de: de, d: d, c: c});
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    sym_in = DATA;
    sb.delete();
    repeat (2) @(posedge low_clk);
    #1 s_rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int off, pulses, last, rel, t_lock;
    bit lk_seen;
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_slip_cnt", slip_cnt, 0);
    chk("rst_de", de_out, 0);
    chk("rst_d", d_out, 0);
    chk("rst_c", {c1_out, c0_out}, 0);
    chk("rst_loss", lock_loss_cnt, 0);
    do_reset();
    // aligned stream: gating before lock, exact lock edge, data and control decode
    send(DATA, 0, 0, 8'h00, 2'b00);
    send(10'b1000000000, 0, 0, 8'h00, 2'b00);
    for (int i = 1; i <= 20; i++) send(T00, i >= LC, 0, 8'h00, 2'b00);
    send(DATA,          1, 1, 8'h00, 2'b00);
    send(10'b1100000000, 1, 1, 8'h01, 2'b00);
    send(10'b1000000000, 1, 1, 8'hFF, 2'b00);
    send(10'b0000000000, 1, 1, 8'hFE, 2'b00);
    send(10'b0011110000, 1, 1, 8'hEE, 2'b00);
    send(10'b0110101010, 1, 1, 8'hFE, 2'b00);
    send(T01,  1, 0, 8'h00, 2'b01);
    send(T10,  1, 0, 8'h00, 2'b10);
    send(T11,  1, 0, 8'h00, 2'b11);
    send(DATA, 1, 1, 8'h00, 2'b11);
    repeat (4) step(DATA);
    chk("sb_drained", sb.size(), 0);
    // misaligned by 3 bits: model rotates one bit per bitslip pulse
    do_reset();
    rel = cyc;
    off = 3;
    pulses = 0;
    last = -1;
    sym_in = rot(T00, off);
    for (int n = 0; n < 12 * PER && !locked; n++) begin
      @(posedge low_clk);
      #1;
      if (bitslip) begin
        pulses++;
        chk("slip_gap", last < 0 ? cyc - rel : cyc - last, last < 0 ? SW + 1 : PER);
        last = cyc;
        off = (off + 1) % 10;
      end
      sym_in = rot(T00, off);
    end
    chk("mis_locked", locked, 1);
    chk("mis_slip_cnt", slip_cnt, 7);
    chk("mis_pulses", pulses, 7);
    // runs of 15 tokens never lock; slip_cnt wraps 9 -> 0
    do_reset();
    pulses = 0;
    lk_seen = 0;
    for (int n = 0; n < 11 * PER && pulses < 10; n++) begin
      @(posedge low_clk);
      #1;
      if (locked) lk_seen = 1;
      if (bitslip) begin
        pulses++;
        chk("wrap_cnt", slip_cnt, pulses % 10);
      end
      sym_in = (n % 16) < 15 ? T00 : DATA;
    end
    chk("wrap_pulses", pulses, 10);
    chk("wrap_never_locked", lk_seen, 0);
    // asynchronous reset during a bitslip pulse
    sym_in = DATA;
    for (int n = 0; n < 2 * PER && !bitslip; n++) @(posedge low_clk) #1;
    chk("arst_pulse_seen", bitslip, 1);
    s_rst = 1'b1;
    #1;
    chk("arst_bitslip", bitslip, 0);
    chk("arst_slip_cnt", slip_cnt, 0);
    chk("arst_outs", {locked, de_out, d_out, c1_out, c0_out}, 0);
    chk("arst_loss", lock_loss_cnt, 0);
    @(posedge low_clk);
    #1 s_rst = 1'b0;
    rel = cyc;
    for (int n = 0; n < 2 * PER && !bitslip; n++) @(posedge low_clk) #1;
    chk("arst_search_restart", cyc - rel, SW + 1);
    chk("arst_slip_cnt_after", slip_cnt, 1);
    // lock loss timing and saturating loss counter
    do_reset();
    for (int k = 0; k < 256; k++) begin
      repeat (LC) step(T00);
      step(DATA);
      for (int n = 0; n < 4 && !locked; n++) step(DATA);
      if (!locked) chk("loss_relock_timeout", locked, 1);
      t_lock = cyc;
      for (int n = 0; n < LW + 4 && locked; n++) step(DATA);
      if (k == 0) begin
        chk("loss_time", cyc - t_lock, LW);
        chk("loss_cnt_1", lock_loss_cnt, STATS ? 1 : 0);
      end
      if (k == 254) chk("loss_cnt_255", lock_loss_cnt, STATS ? 255 : 0);
    end
    chk("loss_unlocked", locked, 0);
    chk("loss_cnt_sat", lock_loss_cnt, STATS ? 255 : 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
